// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/retire stage: exception-bus bit map,
// CSR ecode/esubcode values, FSM states and lane-slice widths.
package wb_pkg;

  localparam int EBUS_INT  = 0;
  localparam int EBUS_PIL  = 1;
  localparam int EBUS_PIS  = 2;
  localparam int EBUS_PIF  = 3;
  localparam int EBUS_PME  = 4;
  localparam int EBUS_PPI  = 5;
  localparam int EBUS_ADEF = 6;
  localparam int EBUS_ADEM = 7;
  localparam int EBUS_ALE  = 8;
  localparam int EBUS_SYS  = 9;
  localparam int EBUS_BRK  = 10;
  localparam int EBUS_INE  = 11;
  localparam int EBUS_IPE  = 12;
  localparam int EBUS_FPD  = 13;
  localparam int EBUS_FPE  = 14;
  localparam int EBUS_TLBR = 15;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_FPD  = 6'h0F;
  localparam logic [5:0] ECODE_FPE  = 6'h12;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  localparam int RF_ADDR_W  = 5;
  localparam int LANE_IDX_W = 2;
  localparam int BYP_META_W = 7;
  localparam int DBG_WE_W   = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [0:0] {ST_RUN, ST_DRAIN} wb_state_e;
  typedef enum logic [1:0] {BADV_NONE, BADV_PC, BADV_VADDR} badv_sel_e;

  typedef struct packed {
    logic [5:0] ecode;
    logic [8:0] esubcode;
    badv_sel_e  badv_sel;
  } ex_info_t;

  // Fixed priority: lowest bus bit wins.
  function automatic ex_info_t decode_ebus(input logic [15:0] e);
    ex_info_t r;
    r = '{ecode: 6'h00, esubcode: 9'd0, badv_sel: BADV_NONE};
    if      (e[EBUS_INT])  r.ecode = ECODE_INT;
    else if (e[EBUS_PIL])  r.ecode = ECODE_PIL;
    else if (e[EBUS_PIS])  r.ecode = ECODE_PIS;
    else if (e[EBUS_PIF])  r.ecode = ECODE_PIF;
    else if (e[EBUS_PME])  r.ecode = ECODE_PME;
    else if (e[EBUS_PPI])  r.ecode = ECODE_PPI;
    else if (e[EBUS_ADEF]) begin r.ecode = ECODE_ADE; r.badv_sel = BADV_PC; end
    else if (e[EBUS_ADEM]) begin
      r.ecode    = ECODE_ADE;
      r.esubcode = ESUBCODE_ADEM;
      r.badv_sel = BADV_VADDR;
    end
    else if (e[EBUS_ALE])  begin r.ecode = ECODE_ALE; r.badv_sel = BADV_VADDR; end
    else if (e[EBUS_SYS])  r.ecode = ECODE_SYS;
    else if (e[EBUS_BRK])  r.ecode = ECODE_BRK;
    else if (e[EBUS_INE])  r.ecode = ECODE_INE;
    else if (e[EBUS_IPE])  r.ecode = ECODE_IPE;
    else if (e[EBUS_FPD])  r.ecode = ECODE_FPD;
    else if (e[EBUS_FPE])  r.ecode = ECODE_FPE;
    else if (e[EBUS_TLBR]) r.ecode = ECODE_TLBR;
    return r;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/wb_ex_sel.sv
// Picks the oldest live lane with an exception or ertn and decodes its cause.
// Purely combinational; no flow control.
module wb_ex_sel
  import wb_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int EBUS_W    = 16
) (
  input  logic [NUM_LANES-1:0]        lane_live,
  input  logic [NUM_LANES*EBUS_W-1:0] ebus,
  input  logic [NUM_LANES-1:0]        ertn,
  output logic [LANE_IDX_W-1:0]       trap_lane,
  output logic                        trap_vld,
  output logic                        trap_is_ex,
  output logic [5:0]                  ecode,
  output logic [8:0]                  esubcode,
  output badv_sel_e                   badv_sel
);

  logic [EBUS_W-1:0] sel_ebus;
  ex_info_t          info;

  // Walk from the youngest lane down so the oldest trapping lane is written last.
  always_comb begin
    trap_vld   = 1'b0;
    trap_lane  = '0;
    trap_is_ex = 1'b0;
    sel_ebus   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_live[i] && ((|ebus[i*EBUS_W +: EBUS_W]) || ertn[i])) begin
        trap_vld   = 1'b1;
        trap_lane  = LANE_IDX_W'(i);
        sel_ebus   = ebus[i*EBUS_W +: EBUS_W];
        trap_is_ex = |ebus[i*EBUS_W +: EBUS_W];
      end
    end
  end

  assign info     = decode_ebus(sel_ebus[15:0]);
  assign ecode    = info.ecode;
  assign esubcode = info.esubcode;
  assign badv_sel = info.badv_sel;

endmodule

// File: rtl/wb_retire.sv
// Multi-lane writeback/retire: one register stage, outputs combinational from it.
// in_ready is always high; groups arriving during flush/drain are dropped.
module wb_retire
  import wb_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int DATA_W       = 32,
  parameter int EBUS_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_LANES-1:0]                in_lane_valid,
  input  logic [NUM_LANES-1:0]                in_rf_we,
  input  logic [NUM_LANES*RF_ADDR_W-1:0]      in_rf_waddr,
  input  logic [NUM_LANES*DATA_W-1:0]         in_result,
  input  logic [NUM_LANES-1:0]                in_res_from_csr,
  input  logic [NUM_LANES*DATA_W-1:0]         in_pc,
  input  logic [NUM_LANES*DATA_W-1:0]         in_vaddr,
  input  logic [NUM_LANES*EBUS_W-1:0]         in_ebus,
  input  logic [NUM_LANES-1:0]                in_ertn,
  input  logic [DATA_W-1:0]                   csr_rvalue,
  output logic [NUM_LANES-1:0]                rf_we,
  output logic [NUM_LANES*RF_ADDR_W-1:0]      rf_waddr,
  output logic [NUM_LANES*DATA_W-1:0]         rf_wdata,
  output logic [NUM_LANES*(DATA_W+BYP_META_W)-1:0] bypass_bus,
  output logic                                csr_ex,
  output logic [5:0]                          csr_ecode,
  output logic [8:0]                          csr_esubcode,
  output logic [DATA_W-1:0]                   csr_era,
  output logic [DATA_W-1:0]                   csr_badv,
  output logic                                csr_badv_we,
  output logic                                csr_ertn,
  output logic                                flush,
  output logic [63:0]                         retired_cnt,
  output logic [NUM_LANES*DATA_W-1:0]         debug_wb_pc,
  output logic [NUM_LANES*DBG_WE_W-1:0]       debug_wb_rf_we,
  output logic [NUM_LANES*RF_ADDR_W-1:0]      debug_wb_rf_wnum,
  output logic [NUM_LANES*DATA_W-1:0]         debug_wb_rf_wdata
);

  logic                           valid_q;
  logic [NUM_LANES-1:0]           lane_valid_q, we_q, csr_q, ertn_q;
  logic [NUM_LANES*RF_ADDR_W-1:0] waddr_q;
  logic [NUM_LANES*DATA_W-1:0]    result_q, pc_q, vaddr_q;
  logic [NUM_LANES*EBUS_W-1:0]    ebus_q;

  logic [NUM_LANES-1:0]  lane_live, retire;
  logic [LANE_IDX_W-1:0] trap_lane;
  logic                  trap_vld, trap_is_ex;
  logic [5:0]            ex_ecode;
  logic [8:0]            ex_esub;
  badv_sel_e             badv_sel;
  wb_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic                  discard;

  assign in_ready  = 1'b1;
  assign discard   = flush || (state == ST_DRAIN);
  assign lane_live = lane_valid_q & {NUM_LANES{valid_q}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      lane_valid_q <= '0;
      we_q         <= '0;
      csr_q        <= '0;
      ertn_q       <= '0;
      waddr_q      <= '0;
      result_q     <= '0;
      pc_q         <= '0;
      vaddr_q      <= '0;
      ebus_q       <= '0;
    end else begin
      valid_q <= in_valid && in_ready && !discard;
      if (in_valid && in_ready) begin
        lane_valid_q <= in_lane_valid;
        we_q         <= in_rf_we;
        csr_q        <= in_res_from_csr;
        ertn_q       <= in_ertn;
        waddr_q      <= in_rf_waddr;
        result_q     <= in_result;
        pc_q         <= in_pc;
        vaddr_q      <= in_vaddr;
        ebus_q       <= in_ebus;
      end
    end
  end

  wb_ex_sel #(.NUM_LANES(NUM_LANES), .EBUS_W(EBUS_W)) u_ex_sel (
    .lane_live  (lane_live),
    .ebus       (ebus_q),
    .ertn       (ertn_q),
    .trap_lane  (trap_lane),
    .trap_vld   (trap_vld),
    .trap_is_ex (trap_is_ex),
    .ecode      (ex_ecode),
    .esubcode   (ex_esub),
    .badv_sel   (badv_sel)
  );

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_W-1:0] wdata;
    // Only lanes strictly older than the trapping lane commit.
    assign retire[i] = lane_live[i] && (!trap_vld || (LANE_IDX_W'(i) < trap_lane));
    assign rf_we[i]  = retire[i] && we_q[i];
    if (i == 0) begin : g_csr
      assign wdata = csr_q[0] ? csr_rvalue : result_q[0 +: DATA_W];
    end else begin : g_res
      assign wdata = result_q[i*DATA_W +: DATA_W];
    end
    assign rf_wdata[i*DATA_W +: DATA_W]          = wdata;
    assign rf_waddr[i*RF_ADDR_W +: RF_ADDR_W]    = waddr_q[i*RF_ADDR_W +: RF_ADDR_W];
    assign bypass_bus[i*(DATA_W+BYP_META_W) +: DATA_W+BYP_META_W] =
      {csr_q[i] & lane_live[i], waddr_q[i*RF_ADDR_W +: RF_ADDR_W], rf_we[i], wdata};
    assign debug_wb_pc[i*DATA_W +: DATA_W]             = pc_q[i*DATA_W +: DATA_W];
    assign debug_wb_rf_we[i*DBG_WE_W +: DBG_WE_W]      = {DBG_WE_W{rf_we[i]}};
    assign debug_wb_rf_wnum[i*RF_ADDR_W +: RF_ADDR_W]  = waddr_q[i*RF_ADDR_W +: RF_ADDR_W];
    assign debug_wb_rf_wdata[i*DATA_W +: DATA_W]       = wdata;
  end

  assign csr_ex       = trap_vld && trap_is_ex;
  assign csr_ertn     = trap_vld && !trap_is_ex;
  assign flush        = trap_vld;
  assign csr_ecode    = csr_ex ? ex_ecode : 6'h00;
  assign csr_esubcode = csr_ex ? ex_esub : 9'd0;
  assign csr_era      = pc_q[trap_lane*DATA_W +: DATA_W];
  assign csr_badv     = (badv_sel == BADV_PC) ? csr_era : vaddr_q[trap_lane*DATA_W +: DATA_W];
  assign csr_badv_we  = csr_ex && (badv_sel != BADV_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            state <= ST_DRAIN;
            cnt   <= CNT_W'(FLUSH_CYCLES);
          end
        end
        ST_DRAIN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_cnt <= '0;
    else        retired_cnt <= retired_cnt + 64'(popcount4(4'(retire)));
  end

endmodule

// File: tb/tb_wb_retire.sv
// Scoreboard bench for wb_retire: directed groups push expected retire/CSR
// results; a negedge monitor pops and compares whenever the DUT commits.
module tb_wb_retire;
  localparam int NL = 2;
  localparam int DW = 32;
  localparam int EW = 16;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [NL-1:0] in_lane_valid, in_rf_we, in_res_from_csr, in_ertn;
  logic [NL*5-1:0] in_rf_waddr;
  logic [NL*DW-1:0] in_result, in_pc, in_vaddr;
  logic [NL*EW-1:0] in_ebus;
  logic [DW-1:0] csr_rvalue;
  logic [NL-1:0] rf_we;
  logic [NL*5-1:0] rf_waddr;
  logic [NL*DW-1:0] rf_wdata;
  logic [NL*(DW+7)-1:0] bypass_bus;
  logic csr_ex, csr_badv_we, csr_ertn, flush;
  logic [5:0] csr_ecode;
  logic [8:0] csr_esubcode;
  logic [DW-1:0] csr_era, csr_badv;
  logic [63:0] retired_cnt;
  logic [NL*DW-1:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [NL*4-1:0] debug_wb_rf_we;
  logic [NL*5-1:0] debug_wb_rf_wnum;

  wb_retire #(.NUM_LANES(NL), .DATA_W(DW), .EBUS_W(EW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_result(in_result), .in_res_from_csr(in_res_from_csr), .in_pc(in_pc),
    .in_vaddr(in_vaddr), .in_ebus(in_ebus), .in_ertn(in_ertn), .csr_rvalue(csr_rvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .bypass_bus(bypass_bus),
    .csr_ex(csr_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .csr_era(csr_era), .csr_badv(csr_badv), .csr_badv_we(csr_badv_we),
    .csr_ertn(csr_ertn), .flush(flush), .retired_cnt(retired_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] era;
    logic [31:0] badv;
    logic        badv_we;
    logic        csrb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int compared = 0;
  int mismatched = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  task automatic push(input logic [1:0] we, input logic [9:0] wa, input logic [63:0] wd,
                      input logic ex, input logic er, input logic [5:0] ec, input logic [8:0] es,
                      input logic [31:0] era, input logic [31:0] badv, input logic bwe,
                      input logic cb);
    exp_t e;
    e.we = we; e.waddr = wa; e.wdata = wd; e.ex = ex; e.ertn = er; e.ecode = ec;
    e.esub = es; e.era = era; e.badv = badv; e.badv_we = bwe; e.csrb = cb;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && ((|rf_we) || csr_ex || csr_ertn)) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: rf_we=%b csr_ex=%b csr_ertn=%b, required no commit",
                 rf_we, csr_ex, csr_ertn);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_we", 64'(rf_we), 64'(mon_e.we));
        chk("rf_waddr", 64'(rf_waddr), 64'(mon_e.waddr));
        chk("rf_wdata", rf_wdata, mon_e.wdata);
        chk("debug_wb_rf_we", 64'(debug_wb_rf_we),
            64'({{4{mon_e.we[1]}}, {4{mon_e.we[0]}}}));
        chk("csr_ex", 64'(csr_ex), 64'(mon_e.ex));
        chk("csr_ertn", 64'(csr_ertn), 64'(mon_e.ertn));
        chk("flush", 64'(flush), 64'(mon_e.ex | mon_e.ertn));
        chk("csr_badv_we", 64'(csr_badv_we), 64'(mon_e.badv_we));
        chk("bypass_csr0", 64'(bypass_bus[DW+6]), 64'(mon_e.csrb));
        if (mon_e.ex) begin
          chk("csr_ecode", 64'(csr_ecode), 64'(mon_e.ecode));
          chk("csr_esubcode", 64'(csr_esubcode), 64'(mon_e.esub));
          chk("csr_era", 64'(csr_era), 64'(mon_e.era));
        end
        if (mon_e.badv_we) chk("csr_badv", 64'(csr_badv), 64'(mon_e.badv));
      end
    end
  end

  task automatic clear_in();
    in_valid = 1'b0; in_lane_valid = '0; in_rf_we = '0; in_res_from_csr = '0;
    in_ertn = '0; in_rf_waddr = '0; in_result = '0; in_pc = '0; in_vaddr = '0; in_ebus = '0;
  endtask

  task automatic set_lane(input int l, input logic lv, input logic we, input logic [4:0] wa,
                          input logic [31:0] res, input logic [31:0] pcv, input logic [31:0] va,
                          input logic [15:0] eb, input logic er, input logic cs);
    in_lane_valid[l] = lv; in_rf_we[l] = we; in_rf_waddr[l*5 +: 5] = wa;
    in_result[l*DW +: DW] = res; in_pc[l*DW +: DW] = pcv; in_vaddr[l*DW +: DW] = va;
    in_ebus[l*EW +: EW] = eb; in_ertn[l] = er; in_res_from_csr[l] = cs;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue();
    in_valid = 1'b1;
    step();
    clear_in();
  endtask

  initial begin
    reset = 1'b0;
    csr_rvalue = '0;
    clear_in();
    #2;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_csr_ex", 64'(csr_ex), 64'd0);
    chk("reset_csr_ertn", 64'(csr_ertn), 64'd0);
    chk("reset_flush", 64'(flush), 64'd0);
    chk("reset_badv_we", 64'(csr_badv_we), 64'd0);
    chk("reset_retired_cnt", retired_cnt, 64'd0);
    #21 reset = 1'b1;
    step();

    // Two-lane normal retire.
    set_lane(0, 1'b1, 1'b1, 5'd4, 32'h11, 32'h1c00_0000, 32'h0, 16'h0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd5, 32'h22, 32'h1c00_0004, 32'h0, 16'h0, 1'b0, 1'b0);
    push(2'b11, {5'd5, 5'd4}, {32'h22, 32'h11}, 1'b0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue();
    idle(1);
    chk("retired_after_normal", retired_cnt, 64'd2);

    // Lane 1 SYS: lane 0 commits, flush, drain drops three garbage groups.
    set_lane(0, 1'b1, 1'b1, 5'd6, 32'h33, 32'h1c00_0100, 32'h0, 16'h0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd7, 32'h44, 32'h1c00_0104, 32'h0, 16'h0200, 1'b0, 1'b0);
    push(2'b01, {5'd7, 5'd6}, {32'h44, 32'h33}, 1'b1, 1'b0, 6'h0B, 9'h0, 32'h1c00_0104,
         32'h0, 1'b0, 1'b0);
    issue();
    set_lane(0, 1'b1, 1'b1, 5'd20, 32'hBAD0, 32'h1c00_0108, 32'h0, 16'h0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd21, 32'hBAD1, 32'h1c00_010c, 32'h0, 16'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    idle(1);
    chk("flush_one_cycle", 64'(flush), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    chk("retired_after_sys", retired_cnt, 64'd3);
    idle(2);
    clear_in();
    idle(2);
    chk("retired_after_drain", retired_cnt, 64'd3);

    // Lane 0 ADEM.
    set_lane(0, 1'b1, 1'b1, 5'd8, 32'h88, 32'h1c00_0200, 32'h1003, 16'h0080, 1'b0, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd9, 32'h99, 32'h1c00_0204, 32'h0, 16'h0, 1'b0, 1'b0);
    push(2'b00, {5'd9, 5'd8}, {32'h99, 32'h88}, 1'b1, 1'b0, 6'h08, 9'h1, 32'h1c00_0200,
         32'h1003, 1'b1, 1'b0);
    issue();
    idle(3);

    // Lane 0 ertn.
    set_lane(0, 1'b1, 1'b1, 5'd10, 32'hA0, 32'h1c00_0300, 32'h0, 16'h0, 1'b1, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd11, 32'hA1, 32'h1c00_0304, 32'h0, 16'h0, 1'b0, 1'b0);
    push(2'b00, {5'd11, 5'd10}, {32'hA1, 32'hA0}, 1'b0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h0,
         1'b0, 1'b0);
    issue();
    idle(3);

    // INT + BRK on lane 0: INT has priority.
    set_lane(0, 1'b1, 1'b0, 5'd3, 32'hB0, 32'h1c00_0400, 32'h0, 16'h0401, 1'b0, 1'b0);
    push(2'b00, {5'd0, 5'd3}, {32'h0, 32'hB0}, 1'b1, 1'b0, 6'h00, 9'h0, 32'h1c00_0400,
         32'h0, 1'b0, 1'b0);
    issue();
    idle(3);

    // Lane 0 empty, lane 1 ALE together with ertn: exception wins.
    set_lane(0, 1'b0, 1'b1, 5'd12, 32'hC0, 32'h1c00_0500, 32'h0, 16'h0, 1'b0, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd13, 32'hC1, 32'h1c00_0504, 32'h2002, 16'h0100, 1'b1, 1'b0);
    push(2'b00, {5'd13, 5'd12}, {32'hC1, 32'hC0}, 1'b1, 1'b0, 6'h09, 9'h0, 32'h1c00_0504,
         32'h2002, 1'b1, 1'b0);
    issue();
    idle(3);
    chk("retired_after_traps", retired_cnt, 64'd3);

    // Lane 0 CSR read.
    csr_rvalue = 32'hDEAD;
    set_lane(0, 1'b1, 1'b1, 5'd14, 32'h5555, 32'h1c00_0600, 32'h0, 16'h0, 1'b0, 1'b1);
    set_lane(1, 1'b1, 1'b1, 5'd15, 32'h66, 32'h1c00_0604, 32'h0, 16'h0, 1'b0, 1'b0);
    push(2'b11, {5'd15, 5'd14}, {32'h66, 32'hDEAD}, 1'b0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0,
         1'b0, 1'b1);
    issue();
    idle(1);
    csr_rvalue = '0;
    chk("retired_after_csr", retired_cnt, 64'd5);

    // BRK on lane 0, then reset in the middle of the drain window.
    set_lane(0, 1'b1, 1'b1, 5'd16, 32'hD0, 32'h1c00_0700, 32'h0, 16'h0400, 1'b0, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd17, 32'hD1, 32'h1c00_0704, 32'h0, 16'h0, 1'b0, 1'b0);
    push(2'b00, {5'd17, 5'd16}, {32'hD1, 32'hD0}, 1'b1, 1'b0, 6'h0C, 9'h0, 32'h1c00_0700,
         32'h0, 1'b0, 1'b0);
    issue();
    idle(1);
    chk("retired_before_reset", retired_cnt, 64'd5);
    #2 reset = 1'b0;
    #1;
    chk("async_retired_cnt", retired_cnt, 64'd0);
    chk("async_rf_we", 64'(rf_we), 64'd0);
    chk("async_flush", 64'(flush), 64'd0);
    chk("async_csr_ex", 64'(csr_ex), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    step();

    // First group after reset must commit, so the FSM is back in RUN.
    set_lane(0, 1'b1, 1'b1, 5'd18, 32'h77, 32'h1c00_0800, 32'h0, 16'h0, 1'b0, 1'b0);
    push(2'b01, {5'd0, 5'd18}, {32'h0, 32'h77}, 1'b0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0,
         1'b0, 1'b0);
    issue();
    idle(1);
    chk("retired_after_reset", retired_cnt, 64'd1);
    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
